// File: rtl/ff_delay_line_pkg.sv
// ============================================================================
// ff_pkg : shared defaults and width helper for the ff_delay_line family
// Revision: 1.0
// ============================================================================
`default_nettype none

package ff_pkg;

  localparam int FF_DEFAULT_WIDTH = 8;
  localparam int FF_DEFAULT_DEPTH = 4;

  // Smallest r with 2**r >= n; used to size the occupancy count.
  function automatic int ff_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ff_delay_line_stage.sv
// ============================================================================
// ff_stage : one WIDTH-bit data register plus its valid bit
// Revision: 1.0
// ============================================================================
`default_nettype none

module ff_stage
  import ff_pkg::*;
#(
  parameter int               WIDTH     = FF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr,
  input  logic             en,
  input  logic [WIDTH-1:0] d_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] s,
  output logic             v
);

  logic [WIDTH-1:0] r_s;
  logic             r_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s <= RESET_VAL;
      r_v <= 1'b0;
    end else if (sclr) begin
      r_s <= RESET_VAL;
      r_v <= 1'b0;
    end else if (en) begin
      r_s <= d_in;
      r_v <= v_in;
    end
  end

  assign s = r_s;
  assign v = r_v;

endmodule

`default_nettype wire

// File: rtl/ff_delay_line.sv
// ============================================================================
// ff_delay_line : DEPTH-stage WIDTH-bit delay line with valids, stall, flush,
//                 tap outputs and occupancy count
// Revision: 1.0
// ============================================================================
`default_nettype none

module ff_delay_line
  import ff_pkg::*;
#(
  parameter int               WIDTH     = FF_DEFAULT_WIDTH,
  parameter int               DEPTH     = FF_DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CW        = ff_clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   sclr,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       d,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [CW-1:0]          occupancy
);

  logic [WIDTH-1:0] w_s [DEPTH];
  logic [DEPTH-1:0] w_v;
  logic [WIDTH-1:0] w_d0;
  logic [CW-1:0]    r_occ;

  // Bubbles enter as RESET_VAL so invalid stages never carry stale data.
  assign w_d0 = in_valid ? d : RESET_VAL;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] w_din;
    logic             w_vin;

    if (i == 0) begin : g_head
      assign w_din = w_d0;
      assign w_vin = in_valid;
    end else begin : g_body
      assign w_din = w_s[i-1];
      assign w_vin = w_v[i-1];
    end

    ff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .sclr  (sclr),
      .en    (en),
      .d_in  (w_din),
      .v_in  (w_vin),
      .s     (w_s[i]),
      .v     (w_v[i])
    );

    assign taps[i*WIDTH +: WIDTH] = w_s[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (sclr) begin
      r_occ <= '0;
    end else if (en) begin
      r_occ <= r_occ + CW'(in_valid) - CW'(w_v[DEPTH-1]);
    end
  end

  assign q         = w_s[DEPTH-1];
  assign q_valid   = w_v[DEPTH-1];
  assign occupancy = r_occ;

  a_occ_popcount : assert property (@(posedge clk) disable iff (!rst_n)
                                    int'(r_occ) == $countones(w_v));

endmodule

`default_nettype wire

// File: doc/ff_delay_line.md
Name: ff_delay_line

Overview:
- Parametrised successor to the single-bit D flip-flop.
- A WIDTH-bit, DEPTH-stage chain of D flip-flops with per-stage valid tracking, a global advance enable (stall), synchronous flush, tap outputs and an occupancy counter.
- Used as a configurable pipeline/retiming delay between datapath blocks.

Parameters:
- WIDTH, 8, data bits per stage (>=1).
- DEPTH, 4, number of register stages = latency in advancing cycles (>=1).
- RESET_VAL, 0, WIDTH-bit value loaded into data stages on reset, flush and bubbles.
- CW, $clog2(DEPTH+1), width of the occupancy output (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance enable; 0 = stall, all state holds.
- sclr  in  1  synchronous flush; priority over en.
- in_valid  in  1  qualifies d.
- d  in  WIDTH  input data.
- q  out  WIDTH  data of the last stage, s[DEPTH-1].
- q_valid  out  1  valid of the last stage, v[DEPTH-1].
- taps  out  WIDTH*DEPTH  all stage data; stage i occupies bits [i*WIDTH +: WIDTH].
- occupancy  out  CW  number of stages with v=1.

Behaviour:
- Clock and reset: single clock domain, clk; reset is asynchronous and active-low on rst_n.
- On rst_n=0, immediately and independent of clk:
  - all s[i]=RESET_VAL, all v[i]=0, occupancy=0;
  - hence q=RESET_VAL, q_valid=0, taps = DEPTH copies of RESET_VAL.
- Release of rst_n is synchronous to the next rising clk edge; the first update is at the first edge with rst_n=1.
- Priority at each rising edge: sclr > en > hold.
- sclr=1: all s[i]<=RESET_VAL, v[i]<=0, occupancy<=0. en, in_valid and d are ignored that cycle; the incoming word is dropped.
- sclr=0, en=1:
  - s[0] <= in_valid ? d : RESET_VAL; v[0] <= in_valid.
  - for i=1..DEPTH-1: s[i] <= s[i-1], v[i] <= v[i-1].
  - the word in the last stage is discarded.
- sclr=0, en=0: all stages, valids and occupancy hold. in_valid and d are ignored; input is lost (no backpressure output — the upstream must honour en).
- Latency: a word accepted at edge k appears on q with q_valid=1 after DEPTH advancing edges; with en held at 1, that is edge k+DEPTH-1 of acceptance counted from 0. Stalled cycles do not count.
- Occupancy:
  - registered; on an advancing edge, occupancy <= occupancy + in_valid - v[DEPTH-1].
  - range 0..DEPTH; no overflow or underflow is possible.
  - must always equal the popcount of v (checked by assertion).
- DEPTH=1 is a single registered stage; taps equals q.
- Outputs are purely registered; no combinational path from inputs to outputs.
- Reset mid-operation: asserting rst_n=0 while valid words are in flight discards them immediately; there is no drain.

Decomposition:
- Shared package ff_pkg: constant FF_DEFAULT_WIDTH=8, FF_DEFAULT_DEPTH=4, and a clog2 helper function for CW.
- Natural sub-module: ff_stage, one WIDTH-bit data register plus valid bit with rst_n, sclr and en, instantiated DEPTH times in a generate loop.
- Occupancy counter and output packing stay in the top level.

Test Plan:
- Reset: rst_n=0 mid-cycle with 3 valid words in flight -> q=RESET_VAL, q_valid=0, occupancy=0 immediately, without waiting for a clk edge.
- Streaming: WIDTH=8, DEPTH=4, en=1, in_valid=1, d=0x01,0x02,0x03,... on consecutive cycles -> q=0x01 with q_valid=1 four edges after 0x01 was sampled; then one word per cycle in order; occupancy saturates at 4.
- Bubbles: pattern in_valid=1,0,1 with d=0xAA,0xFF,0xBB -> q sequence 0xAA(v=1), RESET_VAL(v=0), 0xBB(v=1); occupancy peaks at 2.
- Stall: fill 2 words, hold en=0 for 5 cycles while toggling d/in_valid -> taps, q and occupancy=2 unchanged; after en=1 the words emerge at latency 4+5 from entry.
- Flush priority: pipeline full (occupancy=4), drive sclr=1, en=1, in_valid=1, d=0x55 -> next edge all v=0, occupancy=0, 0x55 absent from all taps.
- Parameter sweep: DEPTH=1, WIDTH=1 -> q follows d one edge later when en=1, taps==q; DEPTH=7 -> occupancy reaches 7 and CW=3.
